// File: rtl/bsg_manycore_pkt_encode_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_manycore_pkt_encode_tx
//  Description : Client-side manycore packet transmitter. It turns local
//                store / freeze / unfreeze / lock requests into manycore
//                packets, buffers them in a 2-entry FIFO toward the router
//                over a valid/ready link, and tracks outstanding-request
//                credits. Freeze/unfreeze are fenced: they are only accepted
//                once the FIFO is empty and every credit has come back.
//
//  Packet layout (MSB .. LSB):
//      { addr, op[1:0], op_ex[mask], data, src_y, src_x, y_cord, x_cord }
//
//  Ports:
//      clk_i, reset_i            clock, synchronous active-high reset
//      my_x_i / my_y_i           own coordinates (packet source)
//      req_*                     request channel (valid/ready)
//      v_o / data_o / ready_i    packet link toward the router
//      credit_return_i           one outstanding packet completed
//      credits_o                 credits currently available
//      fence_busy_o              a config request is waiting for drain
//      credit_error_o            sticky: credit returned beyond maximum
//
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_manycore_pkt_encode_tx #(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 16,
    parameter int max_out_credits_p = 16,
    localparam int MASK_W           = data_width_p >> 3,
    localparam int CREDIT_W         = $clog2(max_out_credits_p + 1),
    localparam int packet_width_lp  = addr_width_p + 2 + MASK_W + data_width_p
                                      + 2 * x_cord_width_p + 2 * y_cord_width_p
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,
    input  logic                       req_v_i,
    input  logic [1:0]                 req_type_i,
    input  logic [addr_width_p-1:0]    req_addr_i,
    input  logic [data_width_p-1:0]    req_data_i,
    input  logic [MASK_W-1:0]          req_mask_i,
    input  logic [x_cord_width_p-1:0]  req_x_cord_i,
    input  logic [y_cord_width_p-1:0]  req_y_cord_i,
    output logic                       req_ready_o,
    output logic                       v_o,
    output logic [packet_width_lp-1:0] data_o,
    input  logic                       ready_i,
    input  logic                       credit_return_i,
    output logic [CREDIT_W-1:0]        credits_o,
    output logic                       fence_busy_o,
    output logic                       credit_error_o
);

    localparam logic [1:0] c_TYPE_STORE    = 2'd0;
    localparam logic [1:0] c_TYPE_FREEZE   = 2'd1;
    localparam logic [1:0] c_TYPE_UNFREEZE = 2'd2;
    localparam logic [1:0] c_TYPE_LOCK     = 2'd3;

    localparam logic [1:0] c_OP_STORE  = 2'd1;
    localparam logic [1:0] c_OP_CONFIG = 2'd2;
    localparam logic [1:0] c_OP_LOCK   = 2'd3;

    localparam logic [CREDIT_W-1:0] c_MAX_CREDITS = CREDIT_W'(max_out_credits_p);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [packet_width_lp-1:0]  r_mem [2];
    logic                        r_wptr;
    logic                        r_rptr;
    logic [1:0]                  r_count;
    logic [CREDIT_W-1:0]         r_credits;
    logic                        r_credit_error;

    logic                        w_empty;
    logic                        w_full;
    logic                        w_quiet;
    logic                        w_is_cfg;
    logic                        w_zero_store;
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_push;
    logic                        w_deq;
    logic [1:0]                  w_op;
    logic [MASK_W-1:0]           w_op_ex;
    logic [addr_width_p-1:0]     w_addr;
    logic [data_width_p-1:0]     w_data;
    logic [packet_width_lp-1:0]  w_pkt;

    assign w_empty      = (r_count == 2'd0);
    assign w_full       = (r_count == 2'd2);
    // Quiescent: nothing buffered and nothing outstanding in the network.
    assign w_quiet      = w_empty && (r_credits == c_MAX_CREDITS);
    assign w_is_cfg     = (req_type_i == c_TYPE_FREEZE) || (req_type_i == c_TYPE_UNFREEZE);
    assign w_zero_store = (req_type_i == c_TYPE_STORE) && (req_mask_i == '0);

    // ------------------------------------------------------------------
    // Fence FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        fence_busy_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_cfg) begin
                    w_ready = w_quiet;
                    if (req_v_i && !w_quiet) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else begin
                    w_ready = !w_full && (r_credits != '0);
                end
            end
            S_DRAIN: begin
                fence_busy_o = 1'b1;
                if (w_quiet) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ready is forced low while reset is held so no request slips in.
    assign req_ready_o = w_ready && !reset_i;
    assign w_accept    = req_v_i && req_ready_o;
    // Zero-mask stores are consumed without producing a packet.
    assign w_push      = w_accept && !w_zero_store;
    assign w_deq       = v_o && ready_i;

    // ------------------------------------------------------------------
    // Packet encoding
    // ------------------------------------------------------------------
    always_comb begin
        w_op    = c_OP_STORE;
        w_op_ex = '0;
        w_addr  = req_addr_i;
        w_data  = req_data_i;
        case (req_type_i)
            c_TYPE_STORE: begin
                w_op    = c_OP_STORE;
                w_op_ex = req_mask_i;
            end
            c_TYPE_FREEZE: begin
                w_op   = c_OP_CONFIG;
                w_addr = '0;
                w_data = data_width_p'(1);
            end
            c_TYPE_UNFREEZE: begin
                w_op   = c_OP_CONFIG;
                w_addr = '0;
                w_data = '0;
            end
            c_TYPE_LOCK: begin
                w_op = c_OP_LOCK;
            end
            default: begin
                w_op = c_OP_STORE;
            end
        endcase
    end

    assign w_pkt = {w_addr, w_op, w_op_ex, w_data, my_y_i, my_x_i,
                    req_y_cord_i, req_x_cord_i};

    // ------------------------------------------------------------------
    // 2-entry output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_pkt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign v_o    = !w_empty && !reset_i;
    assign data_o = r_mem[r_rptr];

    // ------------------------------------------------------------------
    // Credit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_credits      <= c_MAX_CREDITS;
            r_credit_error <= 1'b0;
        end else begin
            case ({w_push, credit_return_i})
                2'b10: r_credits <= r_credits - CREDIT_W'(1);
                2'b01: begin
                    if (r_credits == c_MAX_CREDITS) begin
                        r_credit_error <= 1'b1;
                    end else begin
                        r_credits <= r_credits + CREDIT_W'(1);
                    end
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign credits_o      = r_credits;
    assign credit_error_o = r_credit_error;

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_pkt_encode_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_manycore_pkt_encode_tx
//  Description : Self-checking bench: table of single-request encodings plus
//                hand-written sequences for backpressure, fencing, credit
//                exhaustion, zero-mask stores and reset during drain.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bsg_manycore_pkt_encode_tx;

    localparam int XW = 4;
    localparam int YW = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MW = DW >> 3;
    localparam int MAXC = 16;
    localparam int CW = $clog2(MAXC + 1);
    localparam int PW = AW + 2 + MW + DW + 2 * XW + 2 * YW;

    localparam logic [XW-1:0] MY_X = 4'h3;
    localparam logic [YW-1:0] MY_Y = 4'h5;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          req_v_i;
    logic [1:0]    req_type_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_data_i;
    logic [MW-1:0] req_mask_i;
    logic [XW-1:0] req_x_cord_i;
    logic [YW-1:0] req_y_cord_i;
    logic          req_ready_o;
    logic          v_o;
    logic [PW-1:0] data_o;
    logic          ready_i;
    logic          credit_return_i;
    logic [CW-1:0] credits_o;
    logic          fence_busy_o;
    logic          credit_error_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bsg_manycore_pkt_encode_tx #(
        .x_cord_width_p   (XW),
        .y_cord_width_p   (YW),
        .data_width_p     (DW),
        .addr_width_p     (AW),
        .max_out_credits_p(MAXC)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .my_x_i         (MY_X),
        .my_y_i         (MY_Y),
        .req_v_i        (req_v_i),
        .req_type_i     (req_type_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_mask_i     (req_mask_i),
        .req_x_cord_i   (req_x_cord_i),
        .req_y_cord_i   (req_y_cord_i),
        .req_ready_o    (req_ready_o),
        .v_o            (v_o),
        .data_o         (data_o),
        .ready_i        (ready_i),
        .credit_return_i(credit_return_i),
        .credits_o      (credits_o),
        .fence_busy_o   (fence_busy_o),
        .credit_error_o (credit_error_o)
    );

    typedef struct {
        logic [1:0]    typ;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [1:0]    e_op;
        logic [MW-1:0] e_opex;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
    } vec_t;

    function automatic logic [PW-1:0] pkt(input logic [1:0] op, input logic [MW-1:0] opex,
                                          input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                          input logic [XW-1:0] x, input logic [YW-1:0] y);
        return {addr, op, opex, data, MY_Y, MY_X, y, x};
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [MW-1:0] m, input logic [XW-1:0] x, input logic [YW-1:0] y);
        req_type_i   = t;
        req_addr_i   = a;
        req_data_i   = d;
        req_mask_i   = m;
        req_x_cord_i = x;
        req_y_cord_i = y;
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic send(input logic [1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m, input logic [XW-1:0] x, input logic [YW-1:0] y);
        bit got;
        set_req(t, a, d, m, x, y);
        req_v_i = 1'b1;
        #1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (req_ready_o) got = 1'b1;
            tick();
        end
        req_v_i = 1'b0;
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got no accept expected accept type=%0d", t);
        end
    endtask

    task automatic return_credits(input int n);
        credit_return_i = 1'b1;
        for (int i = 0; i < n; i++) tick();
        credit_return_i = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        logic [PW-1:0] held;
        int acc, popped;
        bit got;

        vecs[0] = '{2'd0, 16'h0010, 32'hDEADBEEF, 4'hF, 4'd2, 4'd1, 2'd1, 4'hF, 16'h0010, 32'hDEADBEEF};
        vecs[1] = '{2'd0, 16'h1234, 32'h0BADF00D, 4'h5, 4'd7, 4'd6, 2'd1, 4'h5, 16'h1234, 32'h0BADF00D};
        vecs[2] = '{2'd3, 16'h0ABC, 32'h00000042, 4'h9, 4'd1, 4'd3, 2'd3, 4'h0, 16'h0ABC, 32'h00000042};
        vecs[3] = '{2'd1, 16'hFFFF, 32'hFFFFFFFF, 4'hF, 4'd4, 4'd4, 2'd2, 4'h0, 16'h0000, 32'h00000001};
        vecs[4] = '{2'd2, 16'h5555, 32'hAAAAAAAA, 4'h3, 4'd0, 4'd9, 2'd2, 4'h0, 16'h0000, 32'h00000000};

        reset_i = 1'b1;
        req_v_i = 1'b0;
        ready_i = 1'b1;
        credit_return_i = 1'b0;
        set_req(2'd0, '0, '0, 4'hF, '0, '0);
        tick();
        #1;
        check("rst_ready_low", PW'(req_ready_o), PW'(0));
        tick();
        reset_i = 1'b0;
        tick();
        check("rst_v", PW'(v_o), PW'(0));
        check("rst_credits", PW'(credits_o), PW'(MAXC));
        check("rst_fence", PW'(fence_busy_o), PW'(0));
        check("rst_err", PW'(credit_error_o), PW'(0));

        // ---------------- table-driven encodings ----------------
        foreach (vecs[k]) begin
            send(vecs[k].typ, vecs[k].addr, vecs[k].data, vecs[k].mask, vecs[k].x, vecs[k].y);
            check($sformatf("vec%0d_v", k), PW'(v_o), PW'(1));
            check($sformatf("vec%0d_pkt", k), data_o,
                  pkt(vecs[k].e_op, vecs[k].e_opex, vecs[k].e_addr, vecs[k].e_data, vecs[k].x, vecs[k].y));
            check($sformatf("vec%0d_credits", k), PW'(credits_o), PW'(MAXC - 1));
            return_credits(1);
            check($sformatf("vec%0d_v_drained", k), PW'(v_o), PW'(0));
            check($sformatf("vec%0d_credits_back", k), PW'(credits_o), PW'(MAXC));
        end

        // ---------------- backpressure: 4 stores, ready low 5 cycles ----------------
        acc = 0;
        popped = 0;
        held = '0;
        got = 1'b0;
        for (int c = 0; c < 40 && popped < 4; c++) begin
            ready_i = (c >= 5);
            if (acc < 4) begin
                set_req(2'd0, 16'h0020 + AW'(acc), 32'h100 + DW'(acc), 4'hF, 4'd1, 4'd2);
                req_v_i = 1'b1;
            end else begin
                req_v_i = 1'b0;
            end
            #1;
            if (c == 5) check("bp_accepted_during_stall", PW'(acc), PW'(2));
            if (c > 0 && c < 5 && v_o) begin
                if (got) check("bp_data_stable", data_o, held);
                held = data_o;
                got = 1'b1;
            end
            if (v_o && ready_i) begin
                check($sformatf("bp_order%0d", popped), data_o,
                      pkt(2'd1, 4'hF, 16'h0020 + AW'(popped), 32'h100 + DW'(popped), 4'd1, 4'd2));
                popped++;
            end
            if (req_v_i && req_ready_o) acc++;
            tick();
        end
        req_v_i = 1'b0;
        check("bp_popped", PW'(popped), PW'(4));
        check("bp_credits", PW'(credits_o), PW'(12));
        return_credits(4);
        check("bp_credits_back", PW'(credits_o), PW'(MAXC));

        // ---------------- fence: 3 outstanding then freeze ----------------
        for (int i = 0; i < 3; i++) send(2'd0, 16'h40, 32'h7, 4'h1, 4'd2, 4'd2);
        tick();
        set_req(2'd1, 16'h0, 32'h0, 4'h0, 4'd6, 4'd7);
        req_v_i = 1'b1;
        #1;
        check("fence_ready_low", PW'(req_ready_o), PW'(0));
        tick();
        check("fence_busy", PW'(fence_busy_o), PW'(1));
        check("fence_ready_low_drain", PW'(req_ready_o), PW'(0));
        return_credits(3);
        check("fence_busy_till_quiet", PW'(fence_busy_o), PW'(1));
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (req_ready_o) got = 1'b1;
            tick();
        end
        req_v_i = 1'b0;
        check("fence_accepted", PW'(got), PW'(1));
        check("fence_pkt", data_o, pkt(2'd2, 4'h0, 16'h0, 32'h1, 4'd6, 4'd7));
        check("fence_idle", PW'(fence_busy_o), PW'(0));
        return_credits(1);

        // ---------------- credit exhaustion ----------------
        for (int i = 0; i < MAXC; i++) send(2'd0, AW'(i), DW'(i), 4'hF, 4'd1, 4'd1);
        check("exh_credits_zero", PW'(credits_o), PW'(0));
        set_req(2'd0, 16'h77, 32'h77, 4'hF, 4'd1, 4'd1);
        req_v_i = 1'b1;
        #1;
        check("exh_ready_low", PW'(req_ready_o), PW'(0));
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;
        check("exh_ready_after_return", PW'(req_ready_o), PW'(1));
        tick();
        req_v_i = 1'b0;
        check("exh_credits_back_zero", PW'(credits_o), PW'(0));
        return_credits(MAXC);
        check("exh_restored", PW'(credits_o), PW'(MAXC));
        // simultaneous accept + return
        send(2'd0, 16'h1, 32'h1, 4'hF, 4'd1, 4'd1);
        credit_return_i = 1'b1;
        send(2'd0, 16'h2, 32'h2, 4'hF, 4'd1, 4'd1);
        credit_return_i = 1'b0;
        check("simul_unchanged", PW'(credits_o), PW'(MAXC - 1));
        return_credits(1);

        // ---------------- zero-mask store and over-return ----------------
        tick();
        send(2'd0, 16'h88, 32'h88, 4'h0, 4'd1, 4'd1);
        check("zmask_no_v", PW'(v_o), PW'(0));
        check("zmask_credits", PW'(credits_o), PW'(MAXC));
        check("err_clear_before", PW'(credit_error_o), PW'(0));
        return_credits(1);
        check("err_set", PW'(credit_error_o), PW'(1));
        check("err_credits_max", PW'(credits_o), PW'(MAXC));

        // ---------------- reset in DRAIN with FIFO full ----------------
        ready_i = 1'b0;
        send(2'd0, 16'h90, 32'h90, 4'hF, 4'd1, 4'd1);
        send(2'd0, 16'h91, 32'h91, 4'hF, 4'd1, 4'd1);
        set_req(2'd2, 16'h0, 32'h0, 4'h0, 4'd1, 4'd1);
        req_v_i = 1'b1;
        tick();
        check("rd_fence_busy", PW'(fence_busy_o), PW'(1));
        check("rd_fifo_full_v", PW'(v_o), PW'(1));
        reset_i = 1'b1;
        #1;
        check("rd_v_during_reset", PW'(v_o), PW'(0));
        check("rd_ready_during_reset", PW'(req_ready_o), PW'(0));
        req_v_i = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        check("rd_v_after", PW'(v_o), PW'(0));
        check("rd_credits", PW'(credits_o), PW'(MAXC));
        check("rd_idle", PW'(fence_busy_o), PW'(0));
        check("rd_err_cleared", PW'(credit_error_o), PW'(0));
        ready_i = 1'b1;
        send(2'd3, 16'h0004, 32'hCAFE0001, 4'hA, 4'd5, 4'd2);
        check("rd_lock_pkt", data_o, pkt(2'd3, 4'h0, 16'h0004, 32'hCAFE0001, 4'd5, 4'd2));
        check("rd_lock_credits", PW'(credits_o), PW'(MAXC - 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
